// File: rtl/gray_pixel_sink.sv
// Grayscale pixel sink: FIFO-buffers {bw, gray} words and returns 30-bit RGB on VGA read requests.
// Latency: one cycle from accepted i_read to registered RGB/o_rgb_valid. No backpressure; full drops (sticky o_overflow).
// Build option FALSE_COLOR_EN: map gray to a heat palette instead of replicating it.
module gray_pixel_sink #(
    parameter int DEPTH        = 16,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_vga,
    input  logic                     i_valid,
    input  logic [9:0]               i_color,
    input  logic                     i_bw,
    input  logic                     i_bw_sel,
    input  logic                     i_read,
    output logic [9:0]               o_red,
    output logic [9:0]               o_green,
    output logic [9:0]               o_blue,
    output logic                     o_rgb_valid,
    output logic                     o_frame_done,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q;
    logic [10:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   pix_cnt_q;
    logic [29:0]        rgb_q, rgb_d;
    logic               rgb_valid_q, frame_done_q, overflow_q, underflow_q;

    logic               run, empty, full, push, pop, flush_wr, wr_en;
    logic [PTR_W-1:0]   wr_addr;
    logic [10:0]        din, rd_dat;

    function automatic logic [29:0] color_map(input logic [10:0] ent, input logic bw_sel);
        logic [9:0] g;
        logic [9:0] d2;
        g  = ent[9:0];
        d2 = {g[8:0], 1'b0};
        if (bw_sel)
            return ent[10] ? {3{10'h3FF}} : 30'h0;
`ifdef FALSE_COLOR_EN
        // 1023-2x is just the bitwise inverse of 2x in 10 bits
        else if (!g[9])
            return {10'h000, d2, ~d2};
        else
            return {d2, ~d2, 10'h000};
`else
        else
            return {3{g}};
`endif
    endfunction

    always_comb begin
        run      = (state_q == S_RUN);
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_L);
        pop      = run && !i_vga && i_read && !empty;
        push     = run && !i_vga && i_valid && (!full || pop);
        flush_wr = run && i_vga && i_valid;
        wr_en    = push || flush_wr;
        wr_addr  = flush_wr ? '0 : wr_ptr_q;
        din      = {i_bw, i_color};
        rd_dat   = mem_q[rd_ptr_q];
        rgb_d    = color_map(rd_dat, i_bw_sel);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count only.
    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem_q[wr_addr] <= din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pix_cnt_q    <= '0;
            rgb_q        <= '0;
            rgb_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rgb_q        <= '0;
                    rgb_valid_q  <= 1'b0;
                    frame_done_q <= 1'b0;
                    if (i_vga)
                        state_q <= S_RUN;
                end
                S_RUN: begin
                    if (i_vga) begin
                        // Frame realign: the word arriving with the pulse becomes entry 0
                        wr_ptr_q     <= flush_wr ? PTR_W'(1) : '0;
                        count_q      <= flush_wr ? LVL_W'(1) : '0;
                        rd_ptr_q     <= '0;
                        pix_cnt_q    <= '0;
                        rgb_q        <= '0;
                        rgb_valid_q  <= 1'b0;
                        frame_done_q <= 1'b0;
                        overflow_q   <= 1'b0;
                        underflow_q  <= 1'b0;
                    end else begin
                        if (push)
                            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        if (pop)
                            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                        count_q      <= count_d;
                        rgb_valid_q  <= pop;
                        rgb_q        <= pop ? rgb_d : '0;
                        frame_done_q <= pop && (pix_cnt_q == LAST_PIX);
                        if (pop)
                            pix_cnt_q <= (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + CNT_W'(1);
                        if (i_valid && !push)
                            overflow_q <= 1'b1;
                        if (i_read && empty)
                            underflow_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_red        = rgb_q[29:20];
    assign o_green      = rgb_q[19:10];
    assign o_blue       = rgb_q[9:0];
    assign o_rgb_valid  = rgb_valid_q;
    assign o_frame_done = frame_done_q;
    assign o_level      = count_q;
    assign o_overflow   = overflow_q;
    assign o_underflow  = underflow_q;

endmodule
